// File: rtl/usb_ctrl_request.sv
// -----------------------------------------------------------------------------
// usb_ctrl_request
//
// Executes one USB control request at a time:
//   1. accepts the request fields in IDLE,
//   2. writes the 8-byte SETUP packet into the send queue,
//   3. for device-to-host requests with a non-zero wLength, reads up to
//      min(wLength, MAX_LEN) bytes from the receive queue and presents them
//      on dout. A stalled receive queue aborts with err_timeout,
//   4. pulses done for one cycle and returns to IDLE.
//
// Parameters
//   MAX_LEN   maximum data-stage bytes accepted (1..255)
//   TIMEOUT   idle DATA_IN cycles tolerated before abort (2..65535)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   bm_request_type, b_request, w_value, w_index, w_length   request fields
//   tx_w_en/tx_data   send-queue write port, throttled by tx_full
//   rx_r_en/rx_data   receive-queue read port; data arrives the cycle after
//                     rx_r_en. rx_empty blocks reads
//   dout_valid/dout/dout_last   data-stage byte stream
//   done, err_timeout completion pulse and timeout-abort flag
//   rx_count          bytes delivered for the current or last request
// -----------------------------------------------------------------------------
module usb_ctrl_request #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  bm_request_type,
  input  logic [7:0]  b_request,
  input  logic [15:0] w_value,
  input  logic [15:0] w_index,
  input  logic [15:0] w_length,
  output logic        tx_w_en,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        rx_r_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        dout_valid,
  output logic [7:0]  dout,
  output logic        dout_last,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  rx_count
);

  localparam logic [15:0] MAX_LEN16    = 16'(MAX_LEN);
  localparam logic [7:0]  MAX_LEN8     = 8'(MAX_LEN);
  // The counter value from which one more idle cycle reaches TIMEOUT-1.
  // Leaving on that edge puts the done pulse exactly TIMEOUT cycles after
  // the last read.
  localparam logic [15:0] TIMEOUT_TRIP = 16'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    DATA_IN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_reg, state_next;

  // Captured request; held for the whole request regardless of req_valid.
  logic [7:0]  bm_reg;
  logic [7:0]  b_req_reg;
  logic [15:0] w_value_reg;
  logic [15:0] w_index_reg;
  logic [15:0] w_length_reg;
  logic [7:0]  target_reg;

  logic [2:0]  byte_idx_reg, byte_idx_next;
  logic [7:0]  issued_reg, issued_next;
  logic [7:0]  rx_count_reg, rx_count_next;
  logic [15:0] timeout_reg, timeout_next;
  logic        pending_reg, pending_next;     // read issued last cycle
  logic        timed_out_reg, timed_out_next;

  logic        accept;
  logic        data_stage;
  logic [7:0]  target_in;
  logic [7:0]  rx_count_inc;
  logic [63:0] setup_word;
  logic [7:0]  setup_bytes [8];

  // ---------------------------------------------------------------------------
  // SETUP packet byte table, byte 0 = bmRequestType ... byte 7 = wLength[15:8]
  // ---------------------------------------------------------------------------
  assign setup_word = {w_length_reg, w_index_reg, w_value_reg, b_req_reg, bm_reg};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_setup_bytes
      assign setup_bytes[gi] = setup_word[8*gi +: 8];
    end
  endgenerate

  // Full 16-bit compare so that e.g. wLength = 0x0100 clamps to MAX_LEN
  // instead of truncating to 0.
  assign target_in  = (w_length >= MAX_LEN16) ? MAX_LEN8 : w_length[7:0];
  assign data_stage = bm_reg[7] && (w_length_reg != 16'd0);

  assign rx_count_inc = (rx_count_reg == 8'hFF) ? 8'hFF : rx_count_reg + 8'd1;

  // ---------------------------------------------------------------------------
  // Outputs. Queue strobes are masked during reset so no byte is written or
  // consumed by a request that is being aborted.
  // ---------------------------------------------------------------------------
  assign accept    = (state_reg == IDLE) && req_valid;
  assign req_ready = (state_reg == IDLE) && !rst;
  assign tx_w_en   = (state_reg == SETUP) && !tx_full && !rst;
  assign tx_data   = tx_w_en ? setup_bytes[byte_idx_reg] : 8'd0;
  assign rx_r_en   = (state_reg == DATA_IN) && !rx_empty &&
                     (issued_reg < target_reg) && !rst;

  // rx_data is valid in the cycle after a read; forward it straight out.
  assign dout_valid  = pending_reg;
  assign dout        = pending_reg ? rx_data : 8'd0;
  assign dout_last   = pending_reg && (rx_count_inc == target_reg);
  assign done        = (state_reg == DONE);
  assign err_timeout = (state_reg == DONE) && timed_out_reg;
  assign rx_count    = rx_count_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    byte_idx_next  = byte_idx_reg;
    issued_next    = issued_reg;
    rx_count_next  = rx_count_reg;
    timeout_next   = timeout_reg;
    pending_next   = 1'b0;
    timed_out_next = timed_out_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next     = SETUP;
          byte_idx_next  = 3'd0;
          issued_next    = 8'd0;
          rx_count_next  = 8'd0;
          timeout_next   = 16'd0;
          timed_out_next = 1'b0;
        end
      end

      SETUP: begin
        // The index only moves on cycles that actually write a byte, so a
        // full send queue simply holds the current byte.
        if (tx_w_en) begin
          byte_idx_next = byte_idx_reg + 3'd1;
          if (byte_idx_reg == 3'd7) begin
            state_next = data_stage ? DATA_IN : DONE;
          end
        end
      end

      DATA_IN: begin
        pending_next = rx_r_en;
        if (rx_r_en) begin
          issued_next  = issued_reg + 8'd1;
          timeout_next = 16'd0;
        end else begin
          timeout_next = timeout_reg + 16'd1;
        end

        if (pending_reg) begin
          rx_count_next = rx_count_inc;
        end

        // Completion wins over timeout if both land in the same cycle.
        if (dout_last) begin
          state_next = DONE;
        end else if (!rx_r_en && (timeout_reg == TIMEOUT_TRIP)) begin
          state_next     = DONE;
          timed_out_next = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      byte_idx_reg  <= 3'd0;
      issued_reg    <= 8'd0;
      rx_count_reg  <= 8'd0;
      timeout_reg   <= 16'd0;
      pending_reg   <= 1'b0;
      timed_out_reg <= 1'b0;
      bm_reg        <= 8'd0;
      b_req_reg     <= 8'd0;
      w_value_reg   <= 16'd0;
      w_index_reg   <= 16'd0;
      w_length_reg  <= 16'd0;
      target_reg    <= 8'd0;
    end else begin
      state_reg     <= state_next;
      byte_idx_reg  <= byte_idx_next;
      issued_reg    <= issued_next;
      rx_count_reg  <= rx_count_next;
      timeout_reg   <= timeout_next;
      pending_reg   <= pending_next;
      timed_out_reg <= timed_out_next;
      if (accept) begin
        bm_reg       <= bm_request_type;
        b_req_reg    <= b_request;
        w_value_reg  <= w_value;
        w_index_reg  <= w_index;
        w_length_reg <= w_length;
        target_reg   <= target_in;
      end
    end
  end

endmodule

// File: tb/tb_usb_ctrl_request.sv
// -----------------------------------------------------------------------------
// tb_usb_ctrl_request
//
// Table of control requests with expected data-stage results, run one after
// another through a behavioural send/receive queue environment. Expected tx
// and dout bytes are queued when a request is prepared and popped as the DUT
// produces them. Finishes with a mid-data-stage reset and a recovery request.
// -----------------------------------------------------------------------------
module tb_usb_ctrl_request;

  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  bm_request_type = 8'd0;
  logic [7:0]  b_request = 8'd0;
  logic [15:0] w_value = 16'd0;
  logic [15:0] w_index = 16'd0;
  logic [15:0] w_length = 16'd0;
  logic        tx_w_en;
  logic [7:0]  tx_data;
  logic        tx_full = 1'b0;
  logic        rx_r_en;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_empty = 1'b1;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        dout_last;
  logic        done;
  logic        err_timeout;
  logic [7:0]  rx_count;

  usb_ctrl_request #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .bm_request_type(bm_request_type), .b_request(b_request),
    .w_value(w_value), .w_index(w_index), .w_length(w_length),
    .tx_w_en(tx_w_en), .tx_data(tx_data), .tx_full(tx_full),
    .rx_r_en(rx_r_en), .rx_data(rx_data), .rx_empty(rx_empty),
    .dout_valid(dout_valid), .dout(dout), .dout_last(dout_last),
    .done(done), .err_timeout(err_timeout), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bm;
    logic [7:0]  breq;
    logic [15:0] wval;
    logic [15:0] widx;
    logic [15:0] wlen;
    int          n_rx;       // bytes preloaded into the receive queue
    bit          stall;      // tx_full high 3 cycles after tx byte 3
    bit          hold;       // keep req_valid high with junk fields
    int          exp_reads;
    int          exp_count;
    bit          exp_to;
    bit          exp_last;
  } vec_t;

  vec_t vecs [9];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rxq [$];
  logic [7:0] exp_tx [$];
  logic [7:0] exp_dout [$];

  int cyc = 0;
  int tx_seen, dout_seen, last_seen, done_seen, to_seen, reads;
  int last_tx_cyc, last_dout_cyc, last_read_cyc, done_cyc;
  int stall_at = -1;
  int stall_left = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Queue environment and output monitor: observe at negedge, update queue
  // inputs just after posedge.
  initial begin : env
    logic       take;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      take = rx_r_en && !rx_empty;
      if (tx_w_en || rx_r_en) chk("tx_rx_exclusive", int'(tx_w_en && rx_r_en), 0);
      if (tx_w_en) begin
        chk("tx_while_full", int'(tx_full), 0);
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          e = exp_tx.pop_front();
          chk("tx_byte", int'(tx_data), int'(e));
        end
        tx_seen++;
        last_tx_cyc = cyc;
      end
      if (rx_r_en) begin
        chk("read_while_empty", int'(rx_empty), 0);
        reads++;
        last_read_cyc = cyc;
      end
      if (dout_valid) begin
        if (exp_dout.size() == 0) chk("dout_unexpected", 1, 0);
        else begin
          e = exp_dout.pop_front();
          chk("dout_byte", int'(dout), int'(e));
        end
        dout_seen++;
        last_dout_cyc = cyc;
        if (dout_last) last_seen++;
      end
      if (dout_last && !dout_valid) chk("last_without_valid", 1, 0);
      if (err_timeout && !done) chk("timeout_without_done", 1, 0);
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        if (err_timeout) to_seen++;
      end
      @(posedge clk);
      #1;
      if (take && rxq.size() > 0) rx_data = rxq.pop_front();
      rx_empty = (rxq.size() == 0);
      if (stall_left > 0 && tx_seen == stall_at) begin
        tx_full = 1'b1;
        stall_left--;
      end else begin
        tx_full = 1'b0;
      end
    end
  end

  task automatic prep_vec(input vec_t v);
    logic [7:0] b;
    tx_seen = 0; dout_seen = 0; last_seen = 0; done_seen = 0; to_seen = 0; reads = 0;
    last_tx_cyc = -1; last_dout_cyc = -1; last_read_cyc = -1; done_cyc = -1;
    for (int k = 0; k < v.n_rx; k++) begin
      b = 8'($urandom);
      rxq.push_back(b);
      if (k < v.exp_reads) exp_dout.push_back(b);
    end
    exp_tx.push_back(v.bm);
    exp_tx.push_back(v.breq);
    exp_tx.push_back(v.wval[7:0]);
    exp_tx.push_back(v.wval[15:8]);
    exp_tx.push_back(v.widx[7:0]);
    exp_tx.push_back(v.widx[15:8]);
    exp_tx.push_back(v.wlen[7:0]);
    exp_tx.push_back(v.wlen[15:8]);
    stall_at   = v.stall ? 3 : -1;
    stall_left = v.stall ? 3 : 0;
  endtask

  task automatic send_req(input vec_t v);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    chk("req_ready_before_request", int'(req_ready), 1);
    bm_request_type = v.bm;
    b_request       = v.breq;
    w_value         = v.wval;
    w_index         = v.widx;
    w_length        = v.wlen;
    req_valid       = 1'b1;
    @(posedge clk);
    #2;
    if (v.hold) begin
      bm_request_type = 8'($urandom);
      b_request       = 8'($urandom);
      w_value         = 16'($urandom);
      w_index         = 16'($urandom);
      w_length        = 16'($urandom);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   w;
    v = vecs[i];
    prep_vec(v);
    send_req(v);
    w = 0;
    while (!done && w < 2000) begin
      tick();
      w++;
    end
    chk("done_within_budget", int'(done), 1);
    req_valid = 1'b0;
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("done_count", done_seen, 1);
    chk("tx_count", tx_seen, 8);
    chk("tx_all_sent", exp_tx.size(), 0);
    chk("read_count", reads, v.exp_reads);
    chk("dout_count", dout_seen, v.exp_reads);
    chk("dout_all_seen", exp_dout.size(), 0);
    chk("rx_left_in_queue", rxq.size(), v.n_rx - v.exp_reads);
    chk("rx_count", int'(rx_count), v.exp_count);
    chk("err_timeout", to_seen, int'(v.exp_to));
    chk("dout_last_count", last_seen, int'(v.exp_last));
    if (v.exp_to)
      chk("timeout_latency", done_cyc - last_read_cyc, TIMEOUT);
    else if (!v.exp_last)
      chk("done_after_last_tx", done_cyc - last_tx_cyc, 1);
    else
      chk("done_after_last_dout", done_cyc - last_dout_cyc, 1);
    $display("vec %0d: req %02h %02h %04h %04h %04h -> tx=%0d reads=%0d dout=%0d rx_count=%0d timeout=%0d",
             i, v.bm, v.breq, v.wval, v.widx, v.wlen, tx_seen, reads, dout_seen, rx_count, to_seen);
    rxq.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;
    //                bm     breq   wval      widx      wlen     n_rx stall hold  reads cnt to    last
    vecs[0] = '{8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 18,  1'b0, 1'b0, 18, 18, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 8'h05, 16'h0007, 16'h0000, 16'h0000, 0,   1'b0, 1'b0, 0,  0,  1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000, 0,   1'b1, 1'b0, 0,  0,  1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0100, 100, 1'b0, 1'b0, 64, 64, 1'b0, 1'b1};
    vecs[4] = '{8'hC0, 8'h01, 16'h1234, 16'h5678, 16'h0004, 2,   1'b0, 1'b0, 2,  2,  1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 16'h0000, 16'h0000, 16'h0010, 5,   1'b0, 1'b0, 0,  0,  1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h06, 16'h0300, 16'h0409, 16'h0040, 64,  1'b0, 1'b0, 64, 64, 1'b0, 1'b1};
    vecs[7] = '{8'h81, 8'h0A, 16'h0000, 16'h0001, 16'h0001, 3,   1'b0, 1'b1, 1,  1,  1'b0, 1'b1};
    vecs[8] = '{8'hA1, 8'hFE, 16'h0000, 16'h0002, 16'h0041, 70,  1'b1, 1'b0, 64, 64, 1'b0, 1'b1};

    // Power-on reset
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_tx_w_en", int'(tx_w_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_rx_r_en", int'(rx_r_en), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_last", int'(dout_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_rx_count", int'(rx_count), 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset in the middle of a GET_DESCRIPTOR data stage.
    prep_vec(vecs[0]);
    send_req(vecs[0]);
    w = 0;
    while (dout_seen < 5 && w < 500) begin
      tick();
      w++;
    end
    chk("abort_reached_data_stage", int'(dout_seen >= 5), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    chk("abort_req_ready", int'(req_ready), 1);
    chk("abort_tx_w_en", int'(tx_w_en), 0);
    chk("abort_tx_data", int'(tx_data), 0);
    chk("abort_rx_r_en", int'(rx_r_en), 0);
    chk("abort_dout_valid", int'(dout_valid), 0);
    chk("abort_dout", int'(dout), 0);
    chk("abort_dout_last", int'(dout_last), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err_timeout", int'(err_timeout), 0);
    chk("abort_rx_count", int'(rx_count), 0);
    tick();
    chk("abort_no_done_pulse", done_seen, 0);
    $display("abort: reset after %0d data bytes, rx_count=%0d, done pulses=%0d",
             dout_seen, rx_count, done_seen);
    rxq.delete();
    exp_dout.delete();
    exp_tx.delete();
    tick();
    tick();

    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
